// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter that shares one block-ROM read port among NUM_REQ requesters.
// Each accepted read returns its ROM data to the same requester ROM_LAT cycles after the address changes.
module rom_read_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 17,
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned ROM_LAT = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic                      flush_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [ADDR_W-1:0]         rom_addr_o,
  input  logic [DATA_W-1:0]         rom_data_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_data_o
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic               rst_seen_q;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;
  logic               win_vld;
  logic               accept;
  logic [ADDR_W-1:0]  sel_addr;
  // One-hot owner tags; stage 0 is loaded on the accept edge, stage ROM_LAT lines up with rom_data
  logic [NUM_REQ-1:0] tag_q [ROM_LAT+1];

  // Round-robin search starting at ptr_q, wrapping modulo NUM_REQ
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((32'(ptr_q) + 32'(k)) % NUM_REQ);
      if (!win_vld && req_i[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (win_vld && !rst_i && !flush_i && !rst_seen_q) begin
      gnt_o[win_idx] = 1'b1;
    end
  end

  assign accept   = |gnt_o;
  assign sel_addr = req_addr_i[32'(win_idx) * ADDR_W +: ADDR_W];

  always_comb begin
    ptr_d      = ptr_q;
    rom_addr_d = rom_addr_q;
    if (flush_i) begin
      ptr_d = '0;
    end else if (accept) begin
      ptr_d      = IDX_W'((32'(win_idx) + 32'd1) % NUM_REQ);
      rom_addr_d = sel_addr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      rom_addr_q <= '0;
      rst_seen_q <= 1'b1;
      for (int s = 0; s <= ROM_LAT; s++) tag_q[s] <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rom_addr_q <= rom_addr_d;
      rst_seen_q <= 1'b0;
      if (flush_i) begin
        for (int s = 0; s <= ROM_LAT; s++) tag_q[s] <= '0;
      end else begin
        tag_q[0] <= gnt_o;
        for (int s = 1; s <= ROM_LAT; s++) tag_q[s] <= tag_q[s-1];
      end
    end
  end

  assign rom_addr_o  = rom_addr_q;
  assign rsp_valid_o = tag_q[ROM_LAT];
  assign rsp_data_o  = (|tag_q[ROM_LAT]) ? rom_data_i : '0;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Scoreboard bench for rom_read_arbiter with a two-register ROM model (data = addr[11:0]).
module tb_rom_read_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ADDR_W  = 17;
  localparam int unsigned DATA_W  = 12;
  localparam int unsigned ROM_LAT = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic                      flush;
  logic [NUM_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]         rom_addr;
  logic [DATA_W-1:0]         rom_data;
  logic [DATA_W-1:0]         rom_d1;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;

  logic [ADDR_W-1:0] ra [NUM_REQ];
  bit                adv;

  typedef struct {
    logic [NUM_REQ-1:0] vld;
    logic [DATA_W-1:0]  data;
    int                 due;
  } sb_t;
  sb_t sb[$];

  int                 n_chk;
  int                 n_pass;
  int                 cyc;
  bit                 live;
  int                 ptr_m;
  bit                 rst_seen_m;
  logic [ADDR_W-1:0]  addr_m;
  logic [NUM_REQ-1:0] last_gnt;
  logic [NUM_REQ-1:0] last_rsp;
  logic [ADDR_W-1:0]  last_addr;
  logic [NUM_REQ-1:0] t2_tbl [5];

  always #5 clk = ~clk;

  assign req_addr = {ra[3], ra[2], ra[1], ra[0]};

  always @(posedge clk) begin
    rom_d1   <= rom_addr[11:0];
    rom_data <= rom_d1;
  end

  rom_read_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .req_addr_i (req_addr),
    .flush_i    (flush),
    .gnt_o      (gnt),
    .rom_addr_o (rom_addr),
    .rom_data_i (rom_data),
    .rsp_valid_o(rsp_valid),
    .rsp_data_o (rsp_data)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    else n_pass++;
  endtask

  function automatic logic [NUM_REQ-1:0] model_gnt();
    logic [NUM_REQ-1:0] g;
    bit found;
    int i;
    g = '0;
    found = 1'b0;
    if (!(rst || flush || rst_seen_m)) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        i = (ptr_m + k) % NUM_REQ;
        if (!found && req[i]) begin
          found = 1'b1;
          g[i] = 1'b1;
        end
      end
    end
    return g;
  endfunction

  // One clock: check at the falling edge, update the model at the rising edge, return 1 time unit later
  task automatic cycle();
    logic [NUM_REQ-1:0] eg;
    logic [NUM_REQ-1:0] ev;
    logic [DATA_W-1:0]  ed;
    sb_t e;
    int w;
    w = -1;
    @(negedge clk);
    eg        = model_gnt();
    last_gnt  = gnt;
    last_rsp  = rsp_valid;
    last_addr = rom_addr;
    if (live) begin
      check("gnt", 32'(gnt), 32'(eg));
      check("rom_addr", 32'(rom_addr), 32'(addr_m));
      ev = '0;
      ed = '0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e  = sb.pop_front();
        ev = e.vld;
        ed = e.data;
      end
      check("rsp_valid", 32'(rsp_valid), 32'(ev));
      check("rsp_data", 32'(rsp_data), 32'(ed));
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      live       = 1'b1;
      ptr_m      = 0;
      addr_m     = '0;
      rst_seen_m = 1'b1;
      sb.delete();
    end else begin
      rst_seen_m = 1'b0;
      if (flush) begin
        ptr_m = 0;
        sb.delete();
      end else if (eg != '0) begin
        w      = $clog2(eg);
        addr_m = ra[w];
        ptr_m  = (w + 1) % NUM_REQ;
        sb.push_back('{eg, ra[w][11:0], cyc + int'(ROM_LAT)});
      end
    end
    #1;
    if (adv && w >= 0) ra[w] = ra[w] + 17'd1;
  endtask

  task automatic idle(input int n);
    req = '0;
    repeat (n) cycle();
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; live = 1'b0;
    ptr_m = 0; rst_seen_m = 1'b0; addr_m = '0;
    rst = 1'b1; req = '0; flush = 1'b0; adv = 1'b1;
    ra[0] = 17'h00010; ra[1] = 17'h00100; ra[2] = 17'h00200; ra[3] = 17'h00300;
    t2_tbl[0] = 4'b0001; t2_tbl[1] = 4'b0010; t2_tbl[2] = 4'b0100;
    t2_tbl[3] = 4'b1000; t2_tbl[4] = 4'b0001;

    repeat (2) cycle();
    rst = 1'b0;
    req = 4'b1111;
    cycle();
    check("rst_gnt_after", 32'(last_gnt), 32'h0);

    // 1: single requester streaming three reads
    req = 4'b0001;
    repeat (3) begin
      cycle();
      check("t1_gnt", 32'(last_gnt), 32'h1);
    end
    idle(4);

    // 2: all requesters, rotation from index 0
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    ra[0] = 17'h00400;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t2_gnt", 32'(last_gnt), 32'(t2_tbl[i]));
    end

    // 3: wrap-around of the pointer
    req = 4'b0010;
    cycle();
    check("t3_gnt1", 32'(last_gnt), 32'h2);
    req = 4'b0011;
    cycle();
    check("t3_wrap", 32'(last_gnt), 32'h1);
    cycle();
    check("t3_next", 32'(last_gnt), 32'h2);
    idle(4);

    // 4: flush kills an in-flight read
    adv = 1'b0;
    ra[2] = 17'h00ABC;
    req = 4'b0100;
    cycle();
    check("t4_gnt2", 32'(last_gnt), 32'h4);
    req = '0;
    flush = 1'b1;
    cycle();
    check("t4_flush_gnt", 32'(last_gnt), 32'h0);
    flush = 1'b0;
    req = 4'b1111;
    cycle();
    check("t4_gnt0", 32'(last_gnt), 32'h1);
    idle(5);

    // 5: reset pulse while streaming
    adv = 1'b1;
    req = 4'b1111;
    repeat (3) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    check("t5_gnt", 32'(last_gnt), 32'h0);
    check("t5_rsp", 32'(last_rsp), 32'h0);
    check("t5_addr", 32'(last_addr), 32'h0);
    cycle();
    check("t5_gnt0", 32'(last_gnt), 32'h1);
    idle(5);

    // 6: toggling requester 3 at the top address
    adv = 1'b0;
    ra[3] = 17'h1FFFF;
    for (int i = 0; i < 8; i++) begin
      req = (i % 2 == 0) ? 4'b1000 : 4'b0000;
      cycle();
    end
    idle(5);

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
